mem_sweeper: RTL and testbench

//  Test sequencer for the 1K x 8 inferred block RAM and its drive. Fills every word with a

---
 rtl/mem_sweeper.sv | 124 ++++++++++++
 tb/tb_mem_sweeper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sweeper.sv
// Block RAM test sequencer: fills the RAM with a seed-derived pattern, then reads every
// word back in address order, holding each byte on cur_byte for display and flagging the first mismatch.
module mem_sweeper #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SEED        = 8'h03,
  parameter int                HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output logic [DATA_W-1:0] cur_byte,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int                CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_WAIT = 3'd3,
    S_SHOW    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] hold_cnt_r;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ SEED;
  endfunction

  // Sweep sequencer: state, RAM drive, display registers and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      hold_cnt_r <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
      cur_byte   <= '0;
      cur_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          mem_we <= 1'b0;
          if (start) begin
            state_r  <= S_FILL;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_di   <= pattern('0);
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
          end
        end
        S_FILL: begin
          if (mem_addr == ADDR_LAST) begin
            state_r  <= S_RD_ADDR;
            mem_we   <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            mem_di   <= pattern(mem_addr + 1'b1);
          end
        end
        S_RD_ADDR: begin
          state_r <= S_RD_WAIT;
        end
        // RAM output for mem_addr is valid here; latch it for display and compare in one edge.
        S_RD_WAIT: begin
          cur_byte <= mem_do;
          cur_addr <= mem_addr;
          if (mem_do == pattern(mem_addr)) begin
            state_r    <= S_SHOW;
            hold_cnt_r <= '0;
          end else begin
            state_r  <= S_ERR;
            error    <= 1'b1;
            err_addr <= mem_addr;
            busy     <= 1'b0;
          end
        end
        S_SHOW: begin
          if (hold_cnt_r == HOLD_LAST) begin
            if (mem_addr == ADDR_LAST) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r  <= S_RD_ADDR;
              mem_addr <= mem_addr + 1'b1;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweeper.sv
// Self-checking bench for mem_sweeper: behavioural RAM with optional read corruption and
// a timeline reference model of the fill and readback.
module tb_mem_sweeper;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do;
  logic [7:0] cur_byte;
  logic [9:0] cur_addr;
  logic       busy;
  logic       done;
  logic       error;
  logic [9:0] err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [0:1023];
  logic       corrupt_en = 1'b0;
  logic [9:0] corrupt_addr = 10'd0;

  mem_sweeper #(
    .ADDR_W(10), .DATA_W(8), .SEED(8'h03), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
    .cur_byte(cur_byte), .cur_addr(cur_addr),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM model; a selected address can be forced to read back as zero.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_di;
    mem_do <= (corrupt_en && mem_addr == corrupt_addr) ? 8'h00 : ram[mem_addr];
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(a % 256) ^ 8'h03;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the first negedge after FILL was entered; returns on the first negedge with mem_we low.
  task automatic check_fill(input string tag);
    int n = 0;
    int bad = 0;
    logic [7:0] first_d = 8'h00;
    logic [7:0] last_d = 8'h00;
    while (mem_we === 1'b1 && n < 1100) begin
      if (mem_addr !== 10'(n) || mem_di !== pat(n) || busy !== 1'b1) bad++;
      if (n == 0) first_d = mem_di;
      if (n == 1023) last_d = mem_di;
      n++;
      @(negedge clk);
    end
    check({tag, "_wr_count"}, 64'(n), 64'd1024);
    check({tag, "_wr_seq"}, 64'(bad), 64'd0);
    check({tag, "_wr_first"}, 64'(first_d), 64'h03);
    check({tag, "_wr_last"}, 64'(last_d), 64'hFC);
    check({tag, "_post_fill"}, {busy, mem_addr}, {1'b1, 10'd0});
  endtask

  // Readback timeline: t=0 is the first cycle after the fill. Address a is read over
  // cycles 6a..6a+5 and shown from cycle 6a+2; the sweep ends at 6*1024 or at the corrupted read.
  task automatic readback(input string tag, input int corrupt, input int start_at);
    int final_t;
    int bad = 0;
    int hold5 = 0;
    int show5 = 0;
    int moves = 0;
    logic [9:0] ma, ca;
    final_t = (corrupt >= 0) ? 2 + 6 * corrupt : 6 * 1024;
    for (int t = 0; t < final_t; t++) begin
      if (mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 ||
          mem_addr !== 10'(t / 6))
        bad++;
      else if (t >= 2 && (cur_addr !== 10'((t - 2) / 6) || cur_byte !== pat((t - 2) / 6)))
        bad++;
      if (t >= 2 && cur_addr == 10'd5) hold5++;
      if (t >= 2 && cur_addr == 10'd5 && mem_addr == 10'd5) show5++;
      start = (t == start_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_rd_trace"}, 64'(bad), 64'd0);
    if (corrupt < 0) begin
      check({tag, "_addr5_period"}, 64'(hold5), 64'd6);
      check({tag, "_addr5_show"}, 64'(show5), 64'd4);
      check({tag, "_final"}, {done, busy, error, cur_addr, cur_byte, mem_addr, mem_we},
            {1'b1, 1'b0, 1'b0, 10'd1023, 8'hFC, 10'd1023, 1'b0});
    end else begin
      check({tag, "_err_flags"}, {error, done, busy, mem_we}, {1'b1, 1'b0, 1'b0, 1'b0});
      check({tag, "_err_addr"}, 64'(err_addr), 64'(corrupt));
      check({tag, "_err_byte"}, {cur_addr, cur_byte}, {10'(corrupt), 8'h00});
    end
    ma = mem_addr;
    ca = cur_addr;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_addr !== ma || cur_addr !== ca || mem_we !== 1'b0) moves++;
    end
    check({tag, "_final_stable"}, 64'(moves), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_seen = 0;
    int waited = 0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b0) wr_seen++;
    end
    check("reset_no_write", 64'(wr_seen), 64'd0);
    check("reset_outputs",
          {mem_we, mem_addr, mem_di, cur_byte, cur_addr, busy, done, error, err_addr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_stays", {busy, mem_we, done, error}, 4'b0000);

    // Clean sweep.
    pulse_start();
    check_fill("sweep1");
    readback("sweep1", -1, -1);

    // Corrupted read of a random low address; start from DONE clears done.
    corrupt_addr = 10'($urandom_range(1, 12));
    corrupt_en = 1'b1;
    pulse_start();
    check("start_in_done", {done, error, mem_we, busy, mem_addr}, {1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
    check_fill("sweep2");
    readback("sweep2", int'(corrupt_addr), -1);

    // Reset in the middle of the fill, with start held too so reset must win.
    corrupt_en = 1'b0;
    pulse_start();
    while (mem_addr != 10'd100 && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    check("reach_addr100", {mem_we, mem_addr}, {1'b1, 10'd100});
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midfill_reset", {mem_we, busy, mem_addr, error, done}, 23'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {mem_we, busy}, 2'b00);

    // Restart, with a start pulse landing while a byte is shown.
    pulse_start();
    check_fill("sweep3");
    readback("sweep3", -1, 6 * $urandom_range(1, 20) + 3);
    pulse_start();
    check("restart_from_done", {done, busy, mem_we, mem_addr, mem_di},
          {1'b0, 1'b1, 1'b1, 10'd0, 8'h03});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
